// File: rtl/tsmap_arbiter.sv
// TS map SRAM arbiter: core reads win every cycle; host gets read/write/set-bits/clear-bits, one transaction at a time.
// Host response 1 cycle after grant (3+ for set/clear); host stalls via grant; optional stall counter under TSMAP_ARB_STATS_EN.
module tsmap_arbiter #(
    parameter int unsigned TSMapSize = 1024,
    parameter int unsigned AddrW     = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             core_cs_i,
    input  logic [AddrW-1:0] core_addr_i,
    output logic [31:0]      core_rdata_o,
    input  logic             host_req_i,
    input  logic [1:0]       host_op_i,
    input  logic [AddrW-1:0] host_addr_i,
    input  logic [31:0]      host_wdata_i,
    output logic             host_gnt_o,
    output logic             host_rvalid_o,
    output logic [31:0]      host_rdata_o,
    output logic             host_err_o,
    output logic             ram_req_o,
    output logic             ram_we_o,
    output logic [AddrW-1:0] ram_addr_o,
    output logic [31:0]      ram_wdata_o,
    input  logic [31:0]      ram_rdata_i,
    output logic [15:0]      host_stall_cnt_o
);
    typedef enum logic [1:0] {IDLE, RMW_RD, RMW_WR, RESP} state_e;

    localparam logic [1:0]   OP_RD    = 2'b00;
    localparam logic [1:0]   OP_WR    = 2'b01;
    localparam logic [AddrW:0] MapLimit = (AddrW+1)'(TSMapSize);

    state_e             state_q, state_d;
    logic [AddrW-1:0]   addr_q, addr_d;
    logic [31:0]        mask_q, mask_d;
    logic               clr_q, clr_d;
    logic [31:0]        old_q, old_d;
    logic [31:0]        new_q, new_d;
    logic               rvalid_q, rvalid_d;
    logic               err_q, err_d;
    logic               rd_pend_q, rd_pend_d;
    logic               fwd_q, fwd_d;
    logic               in_range;

    assign in_range = ({1'b0, host_addr_i} < MapLimit);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mask_d      = mask_q;
        clr_d       = clr_q;
        old_d       = old_q;
        new_d       = new_q;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rd_pend_d   = 1'b0;
        fwd_d       = 1'b0;
        host_gnt_o  = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_wdata_o = '0;

        // Core read owns the SRAM port whenever it strobes, including during reset.
        if (core_cs_i) begin
            ram_req_o  = 1'b1;
            ram_addr_o = core_addr_i;
        end

        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    if (host_req_i && !core_cs_i) begin
                        host_gnt_o = 1'b1;
                        if (!in_range) begin
                            rvalid_d = 1'b1;
                            err_d    = 1'b1;
                        end else begin
                            ram_req_o   = 1'b1;
                            ram_addr_o  = host_addr_i;
                            ram_wdata_o = host_wdata_i;
                            if (host_op_i == OP_RD) begin
                                rvalid_d  = 1'b1;
                                rd_pend_d = 1'b1;
                            end else if (host_op_i == OP_WR) begin
                                ram_we_o = 1'b1;
                                rvalid_d = 1'b1;
                            end else begin
                                addr_d  = host_addr_i;
                                mask_d  = host_wdata_i;
                                clr_d   = host_op_i[0];
                                state_d = RMW_RD;
                            end
                        end
                    end
                end
                RMW_RD: begin
                    old_d   = ram_rdata_i;
                    new_d   = clr_q ? (ram_rdata_i & ~mask_q) : (ram_rdata_i | mask_q);
                    state_d = RMW_WR;
                end
                RMW_WR: begin
                    // A core read of the pending word must see the modified value.
                    if (core_cs_i) begin
                        fwd_d = (core_addr_i == addr_q);
                    end else begin
                        ram_req_o   = 1'b1;
                        ram_we_o    = 1'b1;
                        ram_addr_o  = addr_q;
                        ram_wdata_o = new_q;
                        state_d     = RESP;
                    end
                end
                RESP: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            mask_q    <= '0;
            clr_q     <= 1'b0;
            old_q     <= '0;
            new_q     <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            fwd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            mask_q    <= mask_d;
            clr_q     <= clr_d;
            old_q     <= old_d;
            new_q     <= new_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
            rd_pend_q <= rd_pend_d;
            fwd_q     <= fwd_d;
        end
    end

    assign core_rdata_o  = fwd_q ? new_q : ram_rdata_i;
    assign host_rvalid_o = !rst_i && (rvalid_q || (state_q == RESP));
    assign host_err_o    = !rst_i && err_q;
    assign host_rdata_o  = rst_i               ? 32'h0 :
                           (state_q == RESP)   ? old_q :
                           rd_pend_q           ? ram_rdata_i : 32'h0;

`ifdef TSMAP_ARB_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (host_req_i && !host_gnt_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign host_stall_cnt_o = stall_cnt_q;
`else
    assign host_stall_cnt_o = 16'h0000;
`endif
endmodule

// File: tb/tb_tsmap_arbiter.sv
// Bench for tsmap_arbiter: directed vector table, hand-written multi-cycle sequences, random traffic vs a behavioural model.
module tb_tsmap_arbiter;
    localparam int MAP = 1024;
    localparam int INF = 32'h7fffffff;
    localparam logic [1:0] OP_RD = 2'd0, OP_WR = 2'd1, OP_SET = 2'd2, OP_CLR = 2'd3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        core_cs_i = 1'b0;
    logic [15:0] core_addr_i = '0;
    logic [31:0] core_rdata_o;
    logic        host_req_i = 1'b0;
    logic [1:0]  host_op_i = '0;
    logic [15:0] host_addr_i = '0;
    logic [31:0] host_wdata_i = '0;
    logic        host_gnt_o, host_rvalid_o, host_err_o;
    logic [31:0] host_rdata_o;
    logic        ram_req_o, ram_we_o;
    logic [15:0] ram_addr_o;
    logic [31:0] ram_wdata_o;
    logic [31:0] ram_rdata_i = '0;
    logic [15:0] host_stall_cnt_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [MAP];
    logic [31:0] ref_mem [MAP];
    logic        r_req, r_we;
    logic [15:0] r_addr;
    logic [31:0] r_wdata;

    always #5 clk_i = ~clk_i;

    tsmap_arbiter #(.TSMapSize(1024), .AddrW(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .core_cs_i(core_cs_i), .core_addr_i(core_addr_i), .core_rdata_o(core_rdata_o),
        .host_req_i(host_req_i), .host_op_i(host_op_i), .host_addr_i(host_addr_i),
        .host_wdata_i(host_wdata_i), .host_gnt_o(host_gnt_o), .host_rvalid_o(host_rvalid_o),
        .host_rdata_o(host_rdata_o), .host_err_o(host_err_o),
        .ram_req_o(ram_req_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i),
        .host_stall_cnt_o(host_stall_cnt_o)
    );

    typedef struct {
        string       nm;
        logic        rst, cs;
        logic [15:0] caddr;
        logic        req;
        logic [1:0]  op;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic        e_gnt, e_rv, e_err;
        logic [31:0] e_rd;
        logic        e_rq, e_we, chk_core;
        logic [31:0] e_core;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic rst, input logic cs, input logic [15:0] caddr,
                                input logic req, input logic [1:0] op, input logic [15:0] addr,
                                input logic [31:0] wdata, input logic e_gnt, input logic e_rv,
                                input logic e_err, input logic [31:0] e_rd, input logic e_rq,
                                input logic e_we, input logic chk_core, input logic [31:0] e_core);
        vec_t v;
        v.nm = nm; v.rst = rst; v.cs = cs; v.caddr = caddr; v.req = req; v.op = op;
        v.addr = addr; v.wdata = wdata; v.e_gnt = e_gnt; v.e_rv = e_rv; v.e_err = e_err;
        v.e_rd = e_rd; v.e_rq = e_rq; v.e_we = e_we; v.chk_core = chk_core; v.e_core = e_core;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs, then wait to mid-cycle so outputs are settled for sampling.
    task automatic set_in(input logic rst, input logic cs, input logic [15:0] caddr, input logic req,
                          input logic [1:0] op, input logic [15:0] addr, input logic [31:0] wdata);
        rst_i = rst; core_cs_i = cs; core_addr_i = caddr; host_req_i = req;
        host_op_i = op; host_addr_i = addr; host_wdata_i = wdata;
        #4;
    endtask

    // SRAM model with one-cycle read latency, updated just after the clock edge.
    task automatic tick();
        r_req = ram_req_o; r_we = ram_we_o; r_addr = ram_addr_o; r_wdata = ram_wdata_o;
        @(posedge clk_i);
        #1;
        if (r_req) begin
            if (r_we) mem[r_addr[9:0]] = r_wdata;
            else      ram_rdata_i = mem[r_addr[9:0]];
        end
    endtask

    function automatic logic [15:0] pick_host();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 16'($urandom_range(0, 15));
        if (r < 9) return 16'($urandom_range(1018, 1029));
        return 16'($urandom);
    endfunction

    function automatic logic [15:0] pick_core();
        if ($urandom_range(0, 3) != 0) return 16'($urandom_range(0, 15));
        return 16'($urandom_range(1018, 1023));
    endfunction

    initial begin
        logic        have_req, outstanding, core_pend, exp_gnt, exp_w, exp_rq, exp_we, cs;
        logic [1:0]  h_op;
        logic [15:0] h_addr, caddr, rmw_addr;
        logic [31:0] h_wdata, core_exp, resp_rdata, rmw_new, old;
        logic        resp_err, rmw_vis_pend, rmw_wr_pend;
        int          resp_cyc, free_cyc, rmw_g, rmw_vis_cyc, stall_exp;

        for (int a = 0; a < MAP; a++) mem[a] = $urandom;
        mem[5] = 32'h0000_1234;
        mem[7] = 32'h0000_00F0;

        vecs.push_back(mk("rst_hold",   1,0,0,  1,OP_RD, 5,0,           0,0,0,0,           0,0,0,0));
        vecs.push_back(mk("idle",       0,0,0,  0,OP_RD, 0,0,           0,0,0,0,           0,0,0,0));
        vecs.push_back(mk("rd5_gnt",    0,0,0,  1,OP_RD, 5,0,           1,0,0,0,           1,0,0,0));
        vecs.push_back(mk("rd5_rsp",    0,0,0,  0,OP_RD, 0,0,           0,1,0,32'h1234,    0,0,0,0));
        vecs.push_back(mk("oor_gnt",    0,0,0,  1,OP_WR, 1024,32'h1111, 1,0,0,0,           0,0,0,0));
        vecs.push_back(mk("oor_rsp",    0,0,0,  0,OP_RD, 0,0,           0,1,1,0,           0,0,0,0));
        vecs.push_back(mk("wr9_gnt",    0,0,0,  1,OP_WR, 9,32'hDEADBEEF,1,0,0,0,           1,1,0,0));
        vecs.push_back(mk("wr9_rsp",    0,0,0,  0,OP_RD, 0,0,           0,1,0,0,           0,0,0,0));
        vecs.push_back(mk("rd9_gnt",    0,0,0,  1,OP_RD, 9,0,           1,0,0,0,           1,0,0,0));
        vecs.push_back(mk("rd9_rsp",    0,0,0,  0,OP_RD, 0,0,           0,1,0,32'hDEADBEEF,0,0,0,0));
        vecs.push_back(mk("set7_gnt",   0,0,0,  1,OP_SET,7,32'h0F,      1,0,0,0,           1,0,0,0));
        vecs.push_back(mk("set7_rmwrd", 0,0,0,  0,OP_RD, 0,0,           0,0,0,0,           0,0,0,0));
        vecs.push_back(mk("set7_rmwwr", 0,0,0,  0,OP_RD, 0,0,           0,0,0,0,           1,1,0,0));
        vecs.push_back(mk("set7_rsp",   0,0,0,  0,OP_RD, 0,0,           0,1,0,32'hF0,      0,0,0,0));
        vecs.push_back(mk("clr7_gnt",   0,0,0,  1,OP_CLR,7,32'h01,      1,0,0,0,           1,0,0,0));
        vecs.push_back(mk("clr7_rmwrd", 0,0,0,  1,OP_RD, 5,0,           0,0,0,0,           0,0,0,0));
        vecs.push_back(mk("clr7_core",  0,1,7,  1,OP_RD, 5,0,           0,0,0,0,           1,0,0,0));
        vecs.push_back(mk("clr7_fwd",   0,0,0,  1,OP_RD, 5,0,           0,0,0,0,           1,1,1,32'hFE));
        vecs.push_back(mk("clr7_rsp",   0,0,0,  1,OP_RD, 5,0,           0,1,0,32'hFF,      0,0,0,0));
        vecs.push_back(mk("rd5b_gnt",   0,0,0,  1,OP_RD, 5,0,           1,0,0,0,           1,0,0,0));
        vecs.push_back(mk("rd5b_rsp",   0,0,0,  0,OP_RD, 0,0,           0,1,0,32'h1234,    0,0,0,0));
        vecs.push_back(mk("core9",      0,1,9,  1,OP_WR, 3,32'h55,      0,0,0,0,           1,0,0,0));
        vecs.push_back(mk("wr3_gnt",    0,0,0,  1,OP_WR, 3,32'h55,      1,0,0,0,           1,1,1,32'hDEADBEEF));
        vecs.push_back(mk("wr3_rsp",    0,0,0,  0,OP_RD, 0,0,           0,1,0,0,           0,0,0,0));

        @(posedge clk_i);
        #1;
        foreach (vecs[i]) begin
            set_in(vecs[i].rst, vecs[i].cs, vecs[i].caddr, vecs[i].req, vecs[i].op, vecs[i].addr, vecs[i].wdata);
            chk({vecs[i].nm, ".gnt"},    32'(host_gnt_o),    32'(vecs[i].e_gnt));
            chk({vecs[i].nm, ".rvalid"}, 32'(host_rvalid_o), 32'(vecs[i].e_rv));
            chk({vecs[i].nm, ".ram_req"},32'(ram_req_o),     32'(vecs[i].e_rq));
            chk({vecs[i].nm, ".ram_we"}, 32'(ram_we_o),      32'(vecs[i].e_we));
            if (vecs[i].e_rv) begin
                chk({vecs[i].nm, ".err"},   32'(host_err_o), 32'(vecs[i].e_err));
                chk({vecs[i].nm, ".rdata"}, host_rdata_o,    vecs[i].e_rd);
            end
            if (vecs[i].chk_core) chk({vecs[i].nm, ".core_rdata"}, core_rdata_o, vecs[i].e_core);
            tick();
        end
        chk("mem7_after_rmw", mem[7], 32'hFE);
        chk("mem9_after_wr",  mem[9], 32'hDEADBEEF);
        chk("mem3_after_wr",  mem[3], 32'h55);

        // Reset landing in RMW_WR abandons the set-bits operation.
        set_in(0,0,0, 1,OP_SET,7,32'h100);  chk("rstmid.gnt", 32'(host_gnt_o), 1); tick();
        set_in(0,0,0, 0,OP_RD,0,0);         chk("rstmid.rmwrd_rv", 32'(host_rvalid_o), 0); tick();
        set_in(1,0,0, 0,OP_RD,0,0);
        chk("rstmid.ram_req", 32'(ram_req_o), 0);
        chk("rstmid.rvalid",  32'(host_rvalid_o), 0);
        tick();
        set_in(0,0,0, 1,OP_RD,7,0);
        chk("rstmid.idle_gnt", 32'(host_gnt_o), 1);
        chk("rstmid.no_rv",    32'(host_rvalid_o), 0);
        tick();
        set_in(0,0,0, 0,OP_RD,0,0);
        chk("rstmid.rd_rv",    32'(host_rvalid_o), 1);
        chk("rstmid.rd_data",  host_rdata_o, 32'hFE);
        tick();
        chk("rstmid.mem7", mem[7], 32'hFE);

        // Core holds the port three cycles while the host waits.
        set_in(1,0,0, 0,OP_RD,0,0); tick();
        for (int k = 0; k < 3; k++) begin
            set_in(0,1,16'(k), 1,OP_WR,11,32'hA5);
            chk($sformatf("corehold.gnt%0d", k), 32'(host_gnt_o), 0);
            chk($sformatf("corehold.ram_addr%0d", k), 32'(ram_addr_o), k);
            tick();
        end
        set_in(0,0,0, 1,OP_WR,11,32'hA5);
        chk("corehold.gnt4", 32'(host_gnt_o), 1);
`ifdef TSMAP_ARB_STATS_EN
        chk("corehold.stall", 32'(host_stall_cnt_o), 3);
`else
        chk("corehold.stall", 32'(host_stall_cnt_o), 0);
`endif
        tick();
        set_in(0,0,0, 0,OP_RD,0,0); chk("corehold.rv", 32'(host_rvalid_o), 1); tick();

        // Random traffic against a transaction-level model of the map.
        set_in(1,0,0, 0,OP_RD,0,0); tick();
        for (int a = 0; a < MAP; a++) ref_mem[a] = mem[a];
        have_req = 0; outstanding = 0; core_pend = 0; core_exp = 0;
        h_op = 0; h_addr = 0; h_wdata = 0; resp_rdata = 0; resp_err = 0;
        rmw_vis_pend = 0; rmw_wr_pend = 0; rmw_addr = 0; rmw_new = 0;
        resp_cyc = -1; free_cyc = 0; rmw_g = 0; rmw_vis_cyc = 0; stall_exp = 0;
        for (int c = 0; c < 2000; c++) begin
            // A set/clear becomes visible to core reads once the modify step is done.
            if (rmw_vis_pend && c == rmw_vis_cyc) begin
                ref_mem[rmw_addr[9:0]] = rmw_new;
                rmw_vis_pend = 0;
            end
            cs = ($urandom_range(0, 99) < 35);
            caddr = pick_core();
            if (!have_req && !outstanding && c < 1970 && $urandom_range(0, 99) < 60) begin
                have_req = 1;
                h_op = 2'($urandom_range(0, 3));
                h_addr = pick_host();
                h_wdata = $urandom;
            end
            exp_gnt = have_req && !cs && (c >= free_cyc);
            exp_w = 0;
            if (rmw_wr_pend && c >= rmw_g + 2 && !cs) begin
                exp_w = 1; rmw_wr_pend = 0; resp_cyc = c + 1; free_cyc = c + 2;
            end
            exp_rq = cs || (exp_gnt && h_addr < MAP) || exp_w;
            exp_we = !cs && ((exp_gnt && h_addr < MAP && h_op == OP_WR) || exp_w);
            set_in(0, cs, caddr, have_req, h_op, h_addr, h_wdata);
            chk("rnd.gnt",     32'(host_gnt_o), 32'(exp_gnt));
            chk("rnd.ram_req", 32'(ram_req_o),  32'(exp_rq));
            chk("rnd.ram_we",  32'(ram_we_o),   32'(exp_we));
            if (cs) chk("rnd.ram_addr", 32'(ram_addr_o), 32'(caddr));
            if (core_pend) chk("rnd.core_rdata", core_rdata_o, core_exp);
            core_pend = cs;
            if (cs) core_exp = ref_mem[caddr[9:0]];
            if (c == resp_cyc) begin
                chk("rnd.rvalid", 32'(host_rvalid_o), 1);
                chk("rnd.err",    32'(host_err_o), 32'(resp_err));
                chk("rnd.rdata",  host_rdata_o, resp_rdata);
                outstanding = 0;
            end else begin
                chk("rnd.rvalid", 32'(host_rvalid_o), 0);
            end
            if (have_req && !exp_gnt) stall_exp++;
            if (exp_gnt) begin
                have_req = 0; outstanding = 1;
                if (h_addr >= MAP) begin
                    resp_cyc = c + 1; resp_err = 1; resp_rdata = 0;
                end else if (h_op == OP_RD) begin
                    resp_cyc = c + 1; resp_err = 0; resp_rdata = ref_mem[h_addr[9:0]];
                end else if (h_op == OP_WR) begin
                    resp_cyc = c + 1; resp_err = 0; resp_rdata = 0;
                    ref_mem[h_addr[9:0]] = h_wdata;
                end else begin
                    old = ref_mem[h_addr[9:0]];
                    rmw_new = (h_op == OP_SET) ? (old | h_wdata) : (old & ~h_wdata);
                    rmw_addr = h_addr; rmw_g = c; rmw_vis_cyc = c + 2;
                    rmw_vis_pend = 1; rmw_wr_pend = 1; free_cyc = INF;
                    resp_err = 0; resp_rdata = old;
                end
            end
            tick();
        end
        set_in(0,0,0, 0,OP_RD,0,0);
`ifdef TSMAP_ARB_STATS_EN
        chk("rnd.stall", 32'(host_stall_cnt_o), 32'(stall_exp));
`else
        chk("rnd.stall", 32'(host_stall_cnt_o), 0);
`endif
        tick();
        for (int a = 0; a < 16; a++) chk($sformatf("rnd.mem%0d", a), mem[a], ref_mem[a]);
        for (int a = 1018; a < MAP; a++) chk($sformatf("rnd.mem%0d", a), mem[a], ref_mem[a]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
